// File: rtl/wb_arbiter2_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter2_if
//   Single-master/single-slave Wishbone bundle used on every side of the
//   two-master arbiter (one instance per master port, one for the slave bus).
//
//   Signals (direction given from the bus master's point of view):
//     adr    out  ADR_W  address
//     dat_w  out  DAT_W  write data (master -> slave)
//     we     out  1      write enable
//     sel    out  1      byte select (single lane)
//     stb    out  1      strobe
//     cyc    out  1      bus cycle
//     dat_r  in   DAT_W  read data (slave -> master)
//     ack    in   1      transfer acknowledge
//     err    in   1      watchdog error (only generated by the arbiter)
//
//   Modports:
//     master - the initiator view. err is absent because the downstream slave
//              bus carries no error line; only the arbiter raises err.
//     slave  - the target view. The arbiter presents this modport to each
//              upstream master and drives err back to it.
// -----------------------------------------------------------------------------
interface wb_arbiter2_if #(
  parameter int ADR_W = 36,
  parameter int DAT_W = 32
);
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic             we;
  logic             sel;
  logic             stb;
  logic             cyc;
  logic             ack;
  logic             err;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
//   Two-master Wishbone arbiter. Shares one slave bus between the LIMB(EC)
//   bridge (m0) and a second master (m1, e.g. DMA). Grants are round-robin on
//   ties, held for the whole cyc of the owner (no preemption), and a watchdog
//   ends a stalled transfer with a one-cycle err pulse to the owner instead of
//   letting the bus hang.
//
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous, active-low reset
//     m0     slave modport   upstream master 0 (wins the first tie after reset)
//     m1     slave modport   upstream master 1
//     s      master modport  downstream slave bus
//
//   Parameters:
//     ADR_W    address width
//     DAT_W    data width
//     TIMEOUT  unacked strobe cycles before err; 1..255
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int ADR_W   = 36,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // The watchdog fires while wd holds TIMEOUT-1, i.e. on the TIMEOUT-th
  // consecutive unacked strobe cycle (first strobe cycle sees wd = 0).
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  owner_e           owner, owner_nxt;
  logic             last, last_nxt;   // most recent grant: 0 = m0, 1 = m1
  logic [7:0]       wd, wd_nxt;

  logic [ADR_W-1:0] own_adr;
  logic [DAT_W-1:0] own_dat;
  logic             own_we;
  logic             own_sel;
  logic             own_stb;
  logic             own_cyc;
  logic             wd_fire;

  // ---------------------------------------------------------------------------
  // Owner view: the selected master's request lines, all zero when idle.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_we  = 1'b0;
    own_sel = 1'b0;
    own_stb = 1'b0;
    own_cyc = 1'b0;
    case (owner)
      OWN_M0: begin
        own_adr = m0.adr;
        own_dat = m0.dat_w;
        own_we  = m0.we;
        own_sel = m0.sel;
        own_stb = m0.stb;
        own_cyc = m0.cyc;
      end
      OWN_M1: begin
        own_adr = m1.adr;
        own_dat = m1.dat_w;
        own_we  = m1.we;
        own_sel = m1.sel;
        own_stb = m1.stb;
        own_cyc = m1.cyc;
      end
      default: ;
    endcase
  end

  // An ack in the same cycle always wins, so fire and ack are never both seen.
  assign wd_fire = (wd == WD_LAST) && !s.ack && own_stb;

  // ---------------------------------------------------------------------------
  // Arbitration: only re-evaluated when the bus is idle or the owner has
  // dropped cyc. Because the owner's cyc is already low in the cycle it is
  // released, the slave always sees at least one cycle with cyc low between
  // two owners.
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_nxt = owner;
    last_nxt  = last;
    if (owner == OWN_NONE || !own_cyc) begin
      if (m0.cyc && m1.cyc) begin
        owner_nxt = last ? OWN_M0 : OWN_M1;
      end else if (m0.cyc) begin
        owner_nxt = OWN_M0;
      end else if (m1.cyc) begin
        owner_nxt = OWN_M1;
      end else begin
        owner_nxt = OWN_NONE;
      end
      if (owner_nxt != OWN_NONE) begin
        last_nxt = (owner_nxt == OWN_M1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: counts consecutive unacked strobe cycles of the current owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    wd_nxt = wd;
    if (owner_nxt != owner || s.ack || !own_stb || wd_fire) begin
      wd_nxt = '0;
    end else if (own_cyc) begin
      wd_nxt = wd + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= OWN_NONE;
      last  <= 1'b1;
      wd    <= '0;
    end else begin
      owner <= owner_nxt;
      last  <= last_nxt;
      wd    <= wd_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Slave bus and return paths. All are combinational on the registered owner,
  // so asserting reset clears them immediately through owner = NONE.
  // ---------------------------------------------------------------------------
  assign s.adr   = own_adr;
  assign s.dat_w = own_dat;
  assign s.we    = own_we;
  assign s.sel   = own_sel;
  assign s.stb   = own_stb & ~wd_fire;
  assign s.cyc   = own_cyc;

  // Read data fans out to both masters; it is held at zero while the bus is
  // idle so every output is quiet in reset.
  assign m0.dat_r = (owner == OWN_NONE) ? '0 : s.dat_r;
  assign m1.dat_r = (owner == OWN_NONE) ? '0 : s.dat_r;

  assign m0.ack = s.ack   & (owner == OWN_M0);
  assign m1.ack = s.ack   & (owner == OWN_M1);
  assign m0.err = wd_fire & (owner == OWN_M0);
  assign m1.err = wd_fire & (owner == OWN_M1);

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2
//   Directed self-checking bench for wb_arbiter2 (TIMEOUT = 4). Inputs change
//   1 time unit after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;

  localparam int ADR_W   = 36;
  localparam int DAT_W   = 32;
  localparam int TIMEOUT = 4;

  localparam logic [ADR_W-1:0] A0 = 36'h123456789;
  localparam logic [ADR_W-1:0] A1 = 36'hABCDE0123;
  localparam logic [DAT_W-1:0] D0 = 32'hDEADBEEF;
  localparam logic [DAT_W-1:0] D1 = 32'h5A5A1234;
  localparam logic [DAT_W-1:0] RD = 32'hCAFEF00D;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  wb_arbiter2_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) m0_if ();
  wb_arbiter2_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) m1_if ();
  wb_arbiter2_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) s_if ();

  // The downstream slave has no error line.
  assign s_if.err = 1'b0;

  wb_arbiter2 #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t want < 200000", $time);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic [ADR_W-1:0] adr,
                        input logic [DAT_W-1:0] dat);
    m0_if.cyc = req; m0_if.stb = req; m0_if.we = req; m0_if.sel = req;
    m0_if.adr = adr; m0_if.dat_w = dat;
  endtask

  task automatic set_m1(input logic req, input logic [ADR_W-1:0] adr,
                        input logic [DAT_W-1:0] dat);
    m1_if.cyc = req; m1_if.stb = req; m1_if.we = req; m1_if.sel = req;
    m1_if.adr = adr; m1_if.dat_w = dat;
  endtask

  task automatic idle_all();
    set_m0(1'b0, '0, '0);
    set_m1(1'b0, '0, '0);
    s_if.ack   = 1'b0;
    s_if.dat_r = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_all();
    tick();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reset: outputs held at zero even with requests and ack present.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    set_m0(1'b1, A0, D0);
    set_m1(1'b1, A1, D1);
    s_if.ack = 1'b1; s_if.dat_r = RD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL reset_s_cyc: got %b want 0", s_if.cyc); end
    n_checks++; if (s_if.stb !== 1'b0) begin n_fails++; $display("FAIL reset_s_stb: got %b want 0", s_if.stb); end
    n_checks++; if (s_if.adr !== '0) begin n_fails++; $display("FAIL reset_s_adr: got %h want 0", s_if.adr); end
    n_checks++; if (s_if.dat_w !== '0) begin n_fails++; $display("FAIL reset_s_dat: got %h want 0", s_if.dat_w); end
    n_checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin n_fails++; $display("FAIL reset_acks: got %b%b want 00", m0_if.ack, m1_if.ack); end
    n_checks++; if (m0_if.dat_r !== '0) begin n_fails++; $display("FAIL reset_m0_dat: got %h want 0", m0_if.dat_r); end
    idle_all();
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL post_reset_idle: got %b want 0", s_if.cyc); end
  endtask

  // ---------------------------------------------------------------------------
  // Single request from m0, ack on the 3rd owned cycle.
  // ---------------------------------------------------------------------------
  task automatic test_single();
    int acks = 0;
    tick();
    set_m0(1'b1, A0, D0);
    s_if.dat_r = RD;
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL single_latency: got cyc %b want 0", s_if.cyc); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      s_if.ack = (i == 3);
      @(negedge clk);
      n_checks++; if (s_if.adr !== A0 || s_if.dat_w !== D0) begin n_fails++; $display("FAIL single_bus_%0d: got %h/%h want %h/%h", i, s_if.adr, s_if.dat_w, A0, D0); end
      n_checks++; if (s_if.we !== 1'b1 || s_if.stb !== 1'b1 || s_if.cyc !== 1'b1) begin n_fails++; $display("FAIL single_ctrl_%0d: got we/stb/cyc %b%b%b want 111", i, s_if.we, s_if.stb, s_if.cyc); end
      n_checks++; if (m1_if.ack !== 1'b0) begin n_fails++; $display("FAIL single_m1_ack_%0d: got %b want 0", i, m1_if.ack); end
      if (m0_if.ack === 1'b1) acks++;
      if (i == 3) begin
        n_checks++; if (m0_if.dat_r !== RD) begin n_fails++; $display("FAIL single_rdata: got %h want %h", m0_if.dat_r, RD); end
      end
    end
    tick();
    set_m0(1'b0, '0, '0);
    s_if.ack = 1'b0;
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL single_release: got cyc %b want 0", s_if.cyc); end
    n_checks++; if (acks !== 1) begin n_fails++; $display("FAIL single_ack_count: got %0d want 1", acks); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Tie after reset, handover, and alternation on later ties.
  // ---------------------------------------------------------------------------
  task automatic test_tie();
    do_reset();
    tick();
    set_m0(1'b1, A0, D0);
    set_m1(1'b1, A1, D1);
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL tie_latency: got cyc %b want 0", s_if.cyc); end
    tick();
    @(negedge clk);
    n_checks++; if (s_if.adr !== A0 || s_if.cyc !== 1'b1) begin n_fails++; $display("FAIL tie_m0_first: got adr %h cyc %b want %h 1", s_if.adr, s_if.cyc, A0); end
    tick();
    set_m0(1'b0, '0, '0);
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL handover_gap: got cyc %b want 0", s_if.cyc); end
    tick();
    @(negedge clk);
    n_checks++; if (s_if.adr !== A1 || s_if.cyc !== 1'b1) begin n_fails++; $display("FAIL handover_m1: got adr %h cyc %b want %h 1", s_if.adr, s_if.cyc, A1); end
    tick();
    set_m1(1'b0, '0, '0);
    tick();
    set_m0(1'b1, A0, D0);
    set_m1(1'b1, A1, D1);
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL tie2_idle: got cyc %b want 0", s_if.cyc); end
    tick();
    @(negedge clk);
    n_checks++; if (s_if.adr !== A0) begin n_fails++; $display("FAIL alternate_m0: got adr %h want %h", s_if.adr, A0); end
    tick();
    set_m0(1'b0, '0, '0);
    set_m1(1'b0, '0, '0);
    tick();
    set_m0(1'b1, A0, D0);
    set_m1(1'b1, A1, D1);
    tick();
    @(negedge clk);
    n_checks++; if (s_if.adr !== A1) begin n_fails++; $display("FAIL alternate_m1: got adr %h want %h", s_if.adr, A1); end
    tick();
    idle_all();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Burst hold: m1 keeps the bus for 6 acked beats while m0 waits.
  // ---------------------------------------------------------------------------
  task automatic test_burst();
    tick();
    set_m1(1'b1, A1, D1);
    tick();
    set_m0(1'b1, A0, D0);
    s_if.ack = 1'b1;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      n_checks++; if (s_if.adr !== A1 || m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin n_fails++; $display("FAIL burst_beat_%0d: got adr %h ack m1/m0 %b%b want %h 10", b, s_if.adr, m1_if.ack, m0_if.ack, A1); end
      if (b < 5) tick();
    end
    tick();
    set_m1(1'b0, '0, '0);
    s_if.ack = 1'b0;
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL burst_gap: got cyc %b want 0", s_if.cyc); end
    tick();
    @(negedge clk);
    n_checks++; if (s_if.adr !== A0 || s_if.cyc !== 1'b1) begin n_fails++; $display("FAIL burst_m0_after: got adr %h cyc %b want %h 1", s_if.adr, s_if.cyc, A0); end
    tick();
    idle_all();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog with TIMEOUT = 4: fires every 4th unacked strobe cycle; an ack
  // restarts the count.
  // ---------------------------------------------------------------------------
  task automatic test_watchdog();
    logic want_err;
    tick();
    set_m0(1'b1, A0, D0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      @(negedge clk);
      want_err = (i % 4 == 0);
      n_checks++; if (m0_if.err !== want_err) begin n_fails++; $display("FAIL wd_err_%0d: got %b want %b", i, m0_if.err, want_err); end
      n_checks++; if (s_if.stb !== !want_err) begin n_fails++; $display("FAIL wd_stb_%0d: got %b want %b", i, s_if.stb, !want_err); end
      n_checks++; if (m1_if.err !== 1'b0) begin n_fails++; $display("FAIL wd_m1_err_%0d: got %b want 0", i, m1_if.err); end
    end
    tick();
    set_m0(1'b0, '0, '0);
    tick();
    tick();
    set_m0(1'b1, A0, D0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      s_if.ack = (i == 3);
      @(negedge clk);
      want_err = (i == 7);
      n_checks++; if (m0_if.err !== want_err) begin n_fails++; $display("FAIL wd_ack_err_%0d: got %b want %b", i, m0_if.err, want_err); end
    end
    tick();
    idle_all();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Ack isolation: m1 strobes without a grant while m0 owns the bus.
  // ---------------------------------------------------------------------------
  task automatic test_isolation();
    logic want_ack;
    tick();
    set_m0(1'b1, A0, D0);
    tick();
    set_m1(1'b1, A1, D1);
    for (int i = 0; i < 4; i++) begin
      want_ack = (i % 2 == 1);
      s_if.ack = want_ack;
      @(negedge clk);
      n_checks++; if (m0_if.ack !== want_ack || m1_if.ack !== 1'b0) begin n_fails++; $display("FAIL iso_ack_%0d: got m0/m1 %b%b want %b0", i, m0_if.ack, m1_if.ack, want_ack); end
      n_checks++; if (s_if.adr !== A0) begin n_fails++; $display("FAIL iso_adr_%0d: got %h want %h", i, s_if.adr, A0); end
      tick();
    end
    idle_all();
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Reset mid-transfer while m1 owns the bus.
  // ---------------------------------------------------------------------------
  task automatic test_mid_reset();
    tick();
    set_m1(1'b1, A1, D1);
    tick();
    s_if.ack = 1'b1;
    @(negedge clk);
    n_checks++; if (s_if.adr !== A1 || m1_if.ack !== 1'b1) begin n_fails++; $display("FAIL mrst_pre: got adr %h ack %b want %h 1", s_if.adr, m1_if.ack, A1); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0 || s_if.we !== 1'b0 || s_if.sel !== 1'b0) begin n_fails++; $display("FAIL mrst_ctrl: got cyc/stb/we/sel %b%b%b%b want 0000", s_if.cyc, s_if.stb, s_if.we, s_if.sel); end
    n_checks++; if (s_if.adr !== '0 || s_if.dat_w !== '0) begin n_fails++; $display("FAIL mrst_bus: got %h/%h want 0/0", s_if.adr, s_if.dat_w); end
    n_checks++; if (m1_if.ack !== 1'b0) begin n_fails++; $display("FAIL mrst_ack: got %b want 0", m1_if.ack); end
    set_m0(1'b1, A0, D0);
    s_if.ack = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (s_if.cyc !== 1'b0) begin n_fails++; $display("FAIL mrst_no_resume: got cyc %b want 0", s_if.cyc); end
    tick();
    @(negedge clk);
    n_checks++; if (s_if.adr !== A0 || s_if.cyc !== 1'b1) begin n_fails++; $display("FAIL mrst_m0_wins: got adr %h cyc %b want %h 1", s_if.adr, s_if.cyc, A0); end
    tick();
    idle_all();
    tick();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_watchdog();
    test_isolation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone bus arbiter for the northbridge. Shares the single 36-bit-address, 32-bit-data Wishbone slave bus between the LIMB(EC) bridge master (m0) and a second master (m1, e.g. DMA). Grants are round-robin, held for the full `cyc` duration, and guarded by a bus watchdog. A stalled slave terminates the cycle with an error pulse rather than hanging the bus.

## Interface
- `ADR_W`, 36: address width.
- `DAT_W`, 32: data width.
- `TIMEOUT`, 255: wait-state limit in clk cycles before watchdog error; 1..255.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `m0_adr_i`, `m1_adr_i`  input  ADR_W  master address.
- `m0_dat_i`, `m1_dat_i`  input  DAT_W  master write data.
- `m0_we_i`, `m0_sel_i`, `m0_stb_i`, `m0_cyc_i` (and `m1_*` equivalents)  input  1 each  master control.
- `m0_dat_o`, `m1_dat_o`  output  DAT_W  read data; `s_dat_i` fanned out to both.
- `m0_ack_o`, `m1_ack_o`  output  1  ack, routed to owner only.
- `m0_err_o`, `m1_err_o`  output  1  watchdog error, routed to owner only.
- `s_adr_o`  output  ADR_W  muxed address.
- `s_dat_o`  output  DAT_W  muxed write data.
- `s_we_o`, `s_sel_o`, `s_stb_o`, `s_cyc_o`  output  1 each  muxed control.
- `s_dat_i`  input  DAT_W  slave read data.
- `s_ack_i`  input  1  slave ack.

## Operation
- Registered state `owner` ∈ {NONE, M0, M1}. Registered `last` ∈ {0, 1} holds the most recently granted master.
- Arbitration is evaluated every cycle in which `owner` = NONE, or in which the current owner has `cyc` low.
  - Both `cyc` high: grant the master ≠ `last`.
  - One high: grant that master.
  - None high: `owner` ← NONE.
  - `last` ← granted master on every new grant.
- While the owner holds `cyc` high, `owner` is unchanged regardless of the other master's requests. There is no preemption.
- Slave outputs come from the owner's inputs, combinationally muxed on registered `owner`.
  - `s_stb_o` = owner `stb` & ~wd_fire.
  - `s_cyc_o` = owner `cyc`.
  - When `owner` = NONE, all `s_*_o` outputs are 0.
- `mN_ack_o` = `s_ack_i` & (`owner` == MN). The non-owner never sees ack or err.
- Watchdog: 8-bit counter `wd`.
  - Cleared when `owner` changes, `s_ack_i` = 1, or owner `stb` = 0.
  - Otherwise increments while owner `stb` & `cyc`.
  - wd_fire = (`wd` == TIMEOUT − 1) & ~`s_ack_i` & owner `stb`.
  - On wd_fire, owner `err_o` = 1 for that cycle, `s_stb_o` is forced 0 for that cycle, and `wd` clears.
  - The master must retry or drop `cyc`. The arbiter does not release the grant on error.
- Simultaneous ack and fire cannot occur: ack suppresses fire.

## Timing
- Reset values: `owner` = NONE, `last` = 1 (so m0 wins the first tie), `wd` = 0, all outputs 0.
- Grant latency:
  - A request raised at edge k on an idle bus is sampled at edge k+1.
  - `owner` is valid after edge k+1, and `s_cyc_o`/`s_stb_o` are high from edge k+1.
  - Minimum cost is one idle cycle.
- Handover:
  - Owner drops `cyc` before edge k; a waiting master is granted at edge k.
  - `s_cyc_o` is low for at least the cycle after the owner's drop. Zero-gap handover is not permitted.
- Ack/err/data paths are combinational; zero added latency in both directions.
- Watchdog fires on the TIMEOUT-th consecutive unacked `stb` cycle, counting the first cycle of `stb` as 1.
- Reset asserted mid-cycle:
  - All outputs go to 0 immediately (asynchronously). `owner` = NONE.
  - After deassertion, arbitration restarts from the reset state. No pending transfer is resumed.
- Reset deassertion is synchronized externally; the block makes no guarantee for deassertion within setup of `clk`.

## Test plan
- Single request: m0 raises `cyc`/`stb`, adr=0x123456789, we=1, dat=0xDEADBEEF; slave acks on the 3rd cycle → `s_adr_o`/`s_dat_o` match from edge+1; `m0_ack_o` pulses once; `m1_ack_o` stays 0.
- Tie after reset: m0 and m1 raise `cyc` at the same edge → m0 is granted first. m0 drops `cyc` while m1 is still requesting → m1 is granted at the next edge. Both re-request at the same time → m0 is granted (alternation).
- Burst hold: m1 owns the bus for 6 acked beats while m0 requests continuously → `owner` stays M1 for all 6 beats; m0 is granted only after m1 drops `cyc`.
- Watchdog: TIMEOUT=4, m0 strobes and the slave never acks → `m0_err_o` = 1 on the 4th strobe cycle, `s_stb_o` = 0 in that cycle, `wd` = 0 afterwards. Repeat with an ack on the 3rd cycle → no err.
- Ack isolation: m0 owns the bus and m1 asserts `stb` without a grant; inject `s_ack_i` → only `m0_ack_o` responds; `s_adr_o` never shows m1's address.
- Mid-transfer reset: pull `reset` low while m1 owns the bus → all `s_*_o` outputs are 0 in the same cycle. Release reset with both masters requesting → m0 is granted.
